// File: rtl/cflog_writer_pkg.sv
// Shared definitions for the CF-Log writer: FSM encoding, default log map and entry layout.
// Monitor, writer and TCB linker map must agree on LOG_BASE/LOG_SIZE, so the defaults live here.
package cflog_writer_pkg;

    localparam logic [15:0] DEFAULT_LOG_SIZE   = 16'h0080;
    localparam logic [15:0] DEFAULT_LOG_BASE   = 16'h0400;
    localparam int          DEFAULT_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_SRC  = 2'd1,
        ST_WR_DEST = 2'd2,
        ST_FLUSH   = 2'd3
    } wr_state_t;

    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dest;
    } log_entry_t;

    // Byte address of a log word; 16-bit modulo arithmetic.
    function automatic logic [15:0] log_addr(input logic [15:0] base, input logic [15:0] ptr);
        return base + (ptr << 1);
    endfunction

endpackage

// File: rtl/cflog_writer_fifo.sv
// Small synchronous FIFO buffering (src,dest) log entries while the log RAM stalls.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module cflog_writer_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cflog_writer.sv
// CF-Log writer: turns each (src,dest) control-flow event into two 16-bit RAM writes and
// hands the log to the TCB through a flush_req/flush_ack handshake when full or on command.
module cflog_writer
    import cflog_writer_pkg::*;
#(
    parameter logic [15:0] LOG_SIZE   = DEFAULT_LOG_SIZE,
    parameter logic [15:0] LOG_BASE   = DEFAULT_LOG_BASE,
    parameter int          FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        entry_valid,
    input  logic [15:0] entry_src,
    input  logic [15:0] entry_dest,
    input  logic        flush_cmd,
    input  logic        flush_ack,
    input  logic        mem_ready,
    output logic        mem_wr_en,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] word_ptr,
    output logic        flush_req,
    output logic        overflow,
    output logic        busy
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    wr_state_t   r_state;
    logic [15:0] r_dest;
    logic [15:0] r_word_ptr;
    logic        r_mem_wr_en;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_flush_req;
    logic        r_pending_flush;
    logic        r_overflow;

    log_entry_t  w_push_entry;
    log_entry_t  w_head;
    logic        w_full;
    logic        w_empty;
    logic [CW-1:0] w_fifo_count;
    logic        w_pop;
    logic        w_drop;
    logic        w_ack;
    logic [15:0] w_ptr_inc;

    assign w_push_entry = '{src: entry_src, dest: entry_dest};
    assign w_pop        = (r_state == ST_IDLE) && !w_empty;
    assign w_drop       = entry_valid && w_full && !w_pop;
    assign w_ack        = (r_state == ST_FLUSH) && flush_ack;
    assign w_ptr_inc    = r_word_ptr + 16'd1;

    cflog_writer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (entry_valid),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    // Outputs are registered and updated on the same edge as the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_dest      <= '0;
            r_word_ptr  <= '0;
            r_mem_wr_en <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_flush_req <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pending_flush && w_empty) begin
                        r_state     <= ST_FLUSH;
                        r_flush_req <= 1'b1;
                    end else if (!w_empty) begin
                        r_state     <= ST_WR_SRC;
                        r_dest      <= w_head.dest;
                        r_mem_wr_en <= 1'b1;
                        r_mem_wdata <= w_head.src;
                        r_mem_addr  <= log_addr(LOG_BASE, r_word_ptr);
                    end
                end
                ST_WR_SRC: begin
                    if (mem_ready) begin
                        r_state     <= ST_WR_DEST;
                        r_word_ptr  <= w_ptr_inc;
                        r_mem_wdata <= r_dest;
                        r_mem_addr  <= log_addr(LOG_BASE, w_ptr_inc);
                    end
                end
                ST_WR_DEST: begin
                    if (mem_ready) begin
                        r_word_ptr  <= w_ptr_inc;
                        r_mem_wr_en <= 1'b0;
                        if (w_ptr_inc == LOG_SIZE) begin
                            r_state     <= ST_FLUSH;
                            r_flush_req <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_ack) begin
                        r_state     <= ST_IDLE;
                        r_word_ptr  <= '0;
                        r_flush_req <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A drop in the ack cycle wins so the TCB learns about it on the next drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending_flush <= 1'b0;
            r_overflow      <= 1'b0;
        end else begin
            if (w_ack) begin
                r_pending_flush <= 1'b0;
            end else if (flush_cmd) begin
                r_pending_flush <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_ack) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign mem_wr_en = r_mem_wr_en;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign word_ptr  = r_word_ptr;
    assign flush_req = r_flush_req;
    assign overflow  = r_overflow;
    assign busy      = !w_empty || (r_state != ST_IDLE);

    a_log_map_fits: assert property (@(posedge clk)
        ((17'(LOG_BASE) + {LOG_SIZE, 1'b0}) <= 17'h10000) && !LOG_SIZE[0]);
    a_ptr_bounded: assert property (@(posedge clk) disable iff (!reset_n)
        r_word_ptr <= LOG_SIZE);
    a_fifo_bounded: assert property (@(posedge clk) disable iff (!reset_n)
        w_fifo_count <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_cflog_writer.sv
// Self-checking bench for cflog_writer: directed scenarios plus a randomized phase,
// all scored against a transaction-level model of the log (word queue, pointer, flags).
module tb_cflog_writer;
   import cflog_writer_pkg::*;

   localparam logic [15:0] LOG_SIZE = 16'h0080;
   localparam logic [15:0] LOG_BASE = 16'h0400;
   localparam int          DEPTH    = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        entry_valid = 1'b0;
   logic [15:0] entry_src = '0;
   logic [15:0] entry_dest = '0;
   logic        flush_cmd = 1'b0;
   logic        flush_ack = 1'b0;
   logic        mem_ready = 1'b0;
   logic        mem_wr_en;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] word_ptr;
   logic        flush_req;
   logic        overflow;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [15:0] expWords[$];
   int          mPtr;
   bit          mPending;
   bit          mOverflow;
   bit          prevFlush;
   int          flushWait;

   cflog_writer #(
      .LOG_SIZE   (LOG_SIZE),
      .LOG_BASE   (LOG_BASE),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .entry_valid (entry_valid),
      .entry_src   (entry_src),
      .entry_dest  (entry_dest),
      .flush_cmd   (flush_cmd),
      .flush_ack   (flush_ack),
      .mem_ready   (mem_ready),
      .mem_wr_en   (mem_wr_en),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .word_ptr    (word_ptr),
      .flush_req   (flush_req),
      .overflow    (overflow),
      .busy        (busy)
   );

   // Free-running clock; inputs change and outputs are sampled on the falling edge.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic resetModel();
      expWords.delete();
      mPtr      = 0;
      mPending  = 1'b0;
      mOverflow = 1'b0;
      prevFlush = 1'b0;
      flushWait = 0;
   endtask

   // One clock of stimulus: score what is visible now, drive inputs, then advance the
   // model by what the coming rising edge must do, and move to the next falling edge.
   task automatic applyStimulus(input logic ev, input logic [15:0] src, input logic [15:0] dest,
                                input logic accept, input logic cmd, input logic ack, input logic ready);
      checkOutput("wordPtr", word_ptr, 32'(mPtr));
      checkOutput("overflow", overflow, mOverflow);
      if (flush_req) checkOutput("noWriteInFlush", mem_wr_en, 0);
      if (flush_req && !prevFlush)
         checkOutput("flushCause", (mPtr == int'(LOG_SIZE)) || (mPending && expWords.size() == 0), 1);
      if (mPtr == int'(LOG_SIZE)) checkOutput("fullFlush", flush_req, 1);
      if (mPending && expWords.size() == 0 && !flush_req) flushWait++;
      else flushWait = 0;
      if (flushWait > 0) checkOutput("flushLatency", flushWait <= 3, 1);
      prevFlush = flush_req;

      entry_valid = ev;
      entry_src   = src;
      entry_dest  = dest;
      flush_cmd   = cmd;
      flush_ack   = ack;
      mem_ready   = ready;

      if (mem_wr_en && ready) begin
         checkOutput("writePending", expWords.size() != 0, 1);
         if (expWords.size() != 0) begin
            checkOutput("memAddr", mem_addr, 32'(LOG_BASE + 16'(mPtr * 2)));
            checkOutput("memData", mem_wdata, expWords.pop_front());
            mPtr++;
         end
      end
      if (flush_req && ack) begin
         mPtr      = 0;
         mPending  = 1'b0;
         mOverflow = 1'b0;
      end
      if (cmd) mPending = 1'b1;
      if (ev) begin
         if (accept) begin
            expWords.push_back(src);
            expWords.push_back(dest);
         end else begin
            mOverflow = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic idleCycles(input int n, input logic ready);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, ready);
   endtask

   task automatic drainWords(input int bound);
      int k = 0;
      while (expWords.size() != 0 && k < bound) begin
         applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
         k++;
      end
      checkOutput("drainDone", expWords.size(), 0);
   endtask

   task automatic waitFlush(input int bound);
      int k = 0;
      while (!flush_req && k < bound) begin
         applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
         k++;
      end
      checkOutput("flushSeen", flush_req, 1);
   endtask

   initial begin
      logic ev, cmd, ack, ready, allowed;
      int   k;

      resetModel();
      #12;
      checkOutput("rstWrEn", mem_wr_en, 0);
      checkOutput("rstAddr", mem_addr, 0);
      checkOutput("rstData", mem_wdata, 0);
      checkOutput("rstPtr", word_ptr, 0);
      checkOutput("rstFlush", flush_req, 0);
      checkOutput("rstOvf", overflow, 0);
      checkOutput("rstBusy", busy, 0);
      @(negedge clk);
      reset_n = 1'b1;

      $display("[TB] single event");
      applyStimulus(1'b1, 16'hE0A0, 16'hE100, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("latPush", mem_wr_en, 0);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("latWrEn", mem_wr_en, 1);
      checkOutput("t1Addr", mem_addr, 16'h0400);
      checkOutput("t1Data", mem_wdata, 16'hE0A0);
      checkOutput("t1Busy", busy, 1);
      idleCycles(2, 1'b1);
      checkOutput("t1Ptr", word_ptr, 2);
      checkOutput("t1BusyFall", busy, 0);

      $display("[TB] back-to-back events with stall");
      applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h3333, 16'h4444, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h5555, 16'h6666, 1'b1, 1'b0, 1'b0, 1'b0);
      idleCycles(2, 1'b0);
      drainWords(50);
      checkOutput("t2Ptr", word_ptr, 8);
      checkOutput("t2Ovf", overflow, 0);

      $display("[TB] overflow drop");
      for (int i = 0; i < DEPTH + 2; i++)
         applyStimulus(1'b1, 16'h7000 + 16'(i), 16'h7800 + 16'(i), (i < DEPTH + 1), 1'b0, 1'b0, 1'b0);
      checkOutput("t3OvfSet", overflow, 1);
      idleCycles(2, 1'b0);
      drainWords(80);
      checkOutput("t3Ptr", word_ptr, 18);
      checkOutput("t3OvfSticky", overflow, 1);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      waitFlush(10);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("t3OvfClr", overflow, 0);
      checkOutput("t3PtrRewind", word_ptr, 0);

      $display("[TB] fill whole log");
      for (int i = 0; i < int'(LOG_SIZE) / 2; i++) begin
         k = 0;
         while ((expWords.size() + 1) / 2 >= DEPTH && k < 100) begin
            applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
            k++;
         end
         applyStimulus(1'b1, 16'hA000 + 16'(i), 16'hB000 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b1);
      end
      drainWords(100);
      checkOutput("t4Flush", flush_req, 1);
      checkOutput("t4Ptr", word_ptr, 16'h0080);
      checkOutput("t4LastAddr", mem_addr, 16'h04FE);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("t4Rewind", word_ptr, 0);

      $display("[TB] flush command during write");
      applyStimulus(1'b1, 16'hC000, 16'hC002, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'hC004, 16'hC006, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t5WrSrc", mem_wr_en, 1);
      checkOutput("t5Addr", mem_addr, 16'h0400);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      drainWords(50);
      waitFlush(10);
      idleCycles(3, 1'b1);
      checkOutput("t5Held", word_ptr, 4);
      checkOutput("t5Req", flush_req, 1);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1);

      $display("[TB] reset mid-write");
      applyStimulus(1'b1, 16'hD000, 16'hD002, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t6WrEn", mem_wr_en, 1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("t6AsyncWrEn", mem_wr_en, 0);
      checkOutput("t6AsyncAddr", mem_addr, 0);
      checkOutput("t6AsyncBusy", busy, 0);
      resetModel();
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(1'b1, 16'hE0A0, 16'hE100, 1'b1, 1'b0, 1'b0, 1'b1);
      idleCycles(4, 1'b1);
      checkOutput("t6Ptr", word_ptr, 2);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 1500; c++) begin
         ready   = ($urandom_range(0, 9) < 7);
         allowed = ((expWords.size() + 1) / 2 < DEPTH) &&
                   !(mPending && expWords.size() == 0 && !flush_req);
         ev      = allowed && ($urandom_range(0, 9) < 3);
         cmd     = !flush_req && ($urandom_range(0, 49) == 0);
         ack     = flush_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
         applyStimulus(ev, 16'($urandom), 16'($urandom), 1'b1, cmd, ack, ready);
      end
      k = 0;
      while ((expWords.size() != 0 || flush_req || mPending) && k < 3000) begin
         applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, flush_req, 1'b1);
         k++;
      end
      checkOutput("randDrained", (expWords.size() == 0) && !mPending && !flush_req, 1);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("randBusy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
